// File: rtl/axi_dmac_mem_burst_fifo_pkg.sv
// axi_dmac_pkg: shared types, defaults and sizing helpers for the DMAC memory-side burst FIFO.
package axi_dmac_pkg;

    localparam int DMAC_DATA_WIDTH_MEM = 64;
    localparam int DMAC_ADDR_WIDTH     = 4;

    typedef struct packed {
        logic                           last;
        logic [DMAC_DATA_WIDTH_MEM-1:0] data;
    } beat_t;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic int level_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/axi_dmac_mem_burst_fifo_if.sv
// axi_dmac_stream_if: valid/ready beat stream with last flag, shared by FIFO input and output.
interface axi_dmac_stream_if #(
    parameter int DATA_WIDTH_MEM = 64
);
    logic                      valid;
    logic                      ready;
    logic [DATA_WIDTH_MEM-1:0] data;
    logic                      last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/axi_dmac_mem_burst_fifo_mem.sv
// axi_dmac_burst_fifo_mem: simple dual-port storage, synchronous write, show-ahead read.
module axi_dmac_burst_fifo_mem
    import axi_dmac_pkg::*;
#(
    parameter int WIDTH      = 65,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);

    logic [WIDTH-1:0] mem_q [fifo_depth(ADDR_WIDTH)];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_dmac_mem_burst_fifo.sv
// axi_dmac_mem_burst_fifo: burst-counting beat FIFO feeding the destination resizer.
// DMAC_STORE_AND_FORWARD_EN holds output until a complete burst (or a full FIFO) is stored.
module axi_dmac_mem_burst_fifo
    import axi_dmac_pkg::*;
#(
    parameter int DATA_WIDTH_MEM = DMAC_DATA_WIDTH_MEM,
    parameter int ADDR_WIDTH     = DMAC_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    axi_dmac_stream_if.slave      s,
    axi_dmac_stream_if.master     m,
    output logic [ADDR_WIDTH:0]   level,
    output logic [ADDR_WIDTH:0]   burst_count
);

    localparam int LW = level_width(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] FULL = LW'(fifo_depth(ADDR_WIDTH));

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d, burst_q, burst_d;
    logic                  s_ready_q, s_ready_d;
    logic                  wr, rd;
    logic [DATA_WIDTH_MEM:0] rdata;

    axi_dmac_burst_fifo_mem #(
        .WIDTH      (DATA_WIDTH_MEM + 1),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr),
        .waddr_i (wr_ptr_q),
        .wdata_i ({s.last, s.data}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    // Output validity depends only on registered counters, so no s_* -> m_* path exists.
`ifdef DMAC_STORE_AND_FORWARD_EN
    assign m.valid = (level_q != '0) & ((burst_q != '0) | (level_q == FULL));
`else
    assign m.valid = (level_q != '0);
`endif

    assign m.data      = rdata[DATA_WIDTH_MEM-1:0];
    assign m.last      = rdata[DATA_WIDTH_MEM];
    assign s.ready     = s_ready_q;
    assign level       = level_q;
    assign burst_count = burst_q;

    always_comb begin
        wr        = s.valid & s_ready_q;
        rd        = m.valid & m.ready;
        wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(wr);
        rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(rd);
        level_d   = level_q + LW'(wr) - LW'(rd);
        burst_d   = burst_q + LW'(wr & s.last) - LW'(rd & m.last);
        s_ready_d = (level_d != FULL);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            burst_q   <= '0;
            s_ready_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            burst_q   <= burst_d;
            s_ready_q <= s_ready_d;
        end
    end

endmodule

// File: tb/tb_axi_dmac_mem_burst_fifo.sv
// tb_axi_dmac_mem_burst_fifo: directed vector table plus scoreboarded streaming sequences, DEPTH=4.
module tb_axi_dmac_mem_burst_fifo;

    localparam int DW    = 64;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [AW:0]   level, burst_count;
    int            checks = 0;
    int            errors = 0;
    logic [DW:0]   src_q[$];

    axi_dmac_stream_if #(.DATA_WIDTH_MEM(DW)) s_if();
    axi_dmac_stream_if #(.DATA_WIDTH_MEM(DW)) m_if();

    axi_dmac_mem_burst_fifo #(
        .DATA_WIDTH_MEM (DW),
        .ADDR_WIDTH     (AW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .s           (s_if),
        .m           (m_if),
        .level       (level),
        .burst_count (burst_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sv, sl;
        logic [7:0] sd;
        logic       mr;
        logic       sr, mv;
        logic [7:0] md;
        logic       ml;
        int         lvl, bc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic sv, sl, input logic [7:0] sd, input logic mr,
                               input logic sr, mv, input logic [7:0] md, input logic ml,
                               input int lvl, bc);
        vec_t r;
        r.sv = sv; r.sl = sl; r.sd = sd; r.mr = mr;
        r.sr = sr; r.mv = mv; r.md = md; r.ml = ml; r.lvl = lvl; r.bc = bc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic stream(input bit rnd, input string tag);
        logic [DW:0] exp_q[$];
        logic [DW:0] e;
        int          idx = 0, lvl = 0, bc = 0, cyc = 0;
        logic        pmv = 0, pmr = 0, pml = 0, psv = 0, psr = 0;
        logic [63:0] pmd = '0;
        logic        wr, rd, emv;
        while (idx < src_q.size() || exp_q.size() != 0) begin
            if (cyc++ > 20000) begin
                fail({tag, " timeout"});
                break;
            end
`ifdef DMAC_STORE_AND_FORWARD_EN
            emv = (lvl != 0) && (bc != 0 || lvl == DEPTH);
`else
            emv = (lvl != 0);
`endif
            chk({tag, " m_valid"}, 64'(m_if.valid), 64'(emv));
            chk({tag, " s_ready"}, 64'(s_if.ready), 64'(lvl != DEPTH));
            chk({tag, " level"}, 64'(level), 64'(lvl));
            chk({tag, " burst_count"}, 64'(burst_count), 64'(bc));
            if (pmv && !pmr) begin
                chk({tag, " stall data"}, m_if.data, pmd);
                chk({tag, " stall last"}, 64'(m_if.last), 64'(pml));
            end
            if (!(psv && !psr))
                s_if.valid = (idx < src_q.size()) && (!rnd || $urandom_range(0, 2) != 0);
            if (idx < src_q.size()) begin
                s_if.data = src_q[idx][DW-1:0];
                s_if.last = src_q[idx][DW];
            end
            m_if.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            wr = s_if.valid && s_if.ready;
            rd = m_if.valid && m_if.ready;
            if (rd) begin
                if (exp_q.size() == 0) fail({tag, " pop from empty"});
                else begin
                    e = exp_q.pop_front();
                    chk({tag, " data"}, m_if.data, e[DW-1:0]);
                    chk({tag, " last"}, 64'(m_if.last), 64'(e[DW]));
                    bc -= int'(e[DW]);
                end
            end
            if (wr) begin
                exp_q.push_back(src_q[idx]);
                bc += int'(src_q[idx][DW]);
                idx++;
            end
            lvl += int'(wr) - int'(rd);
            pmv = m_if.valid; pmr = m_if.ready; pmd = m_if.data; pml = m_if.last;
            psv = s_if.valid; psr = s_if.ready;
            @(posedge clk); #1;
        end
        s_if.valid = 1'b0;
        m_if.ready = 1'b0;
        chk({tag, " final level"}, 64'(level), 64'(0));
        chk({tag, " final burst_count"}, 64'(burst_count), 64'(0));
    endtask

    initial begin
        int len;
        s_if.valid = 1'b0; s_if.last = 1'b0; s_if.data = '0; m_if.ready = 1'b0;

`ifdef DMAC_STORE_AND_FORWARD_EN
        tbl.push_back(v(1,0,8'h11,1, 1,0,8'h00,0, 0,0));
        tbl.push_back(v(1,0,8'h22,1, 1,0,8'h00,0, 1,0));
        tbl.push_back(v(1,0,8'h33,1, 1,0,8'h00,0, 2,0));
        tbl.push_back(v(1,1,8'h44,1, 1,0,8'h00,0, 3,0));
        tbl.push_back(v(0,0,8'h00,0, 0,1,8'h11,0, 4,1));
        tbl.push_back(v(0,0,8'h00,1, 0,1,8'h11,0, 4,1));
        tbl.push_back(v(0,0,8'h00,1, 1,1,8'h22,0, 3,1));
        tbl.push_back(v(0,0,8'h00,1, 1,1,8'h33,0, 2,1));
        tbl.push_back(v(0,0,8'h00,1, 1,1,8'h44,1, 1,1));
        tbl.push_back(v(0,0,8'h00,1, 1,0,8'h00,0, 0,0));
`else
        tbl.push_back(v(1,0,8'h11,1, 1,0,8'h00,0, 0,0));
        tbl.push_back(v(1,0,8'h22,1, 1,1,8'h11,0, 1,0));
        tbl.push_back(v(1,0,8'h33,1, 1,1,8'h22,0, 1,0));
        tbl.push_back(v(1,1,8'h44,1, 1,1,8'h33,0, 1,0));
        tbl.push_back(v(0,0,8'h00,1, 1,1,8'h44,1, 1,1));
        tbl.push_back(v(0,0,8'h00,0, 1,0,8'h00,0, 0,0));
        tbl.push_back(v(1,0,8'h01,0, 1,0,8'h00,0, 0,0));
        tbl.push_back(v(1,1,8'h02,0, 1,1,8'h01,0, 1,0));
        tbl.push_back(v(1,0,8'h03,0, 1,1,8'h01,0, 2,1));
        tbl.push_back(v(1,0,8'h04,0, 1,1,8'h01,0, 3,1));
        tbl.push_back(v(1,1,8'h05,0, 0,1,8'h01,0, 4,1));
        tbl.push_back(v(1,1,8'h05,1, 0,1,8'h01,0, 4,1));
        tbl.push_back(v(1,1,8'h05,0, 1,1,8'h02,1, 3,1));
        tbl.push_back(v(0,0,8'h00,1, 0,1,8'h02,1, 4,2));
        tbl.push_back(v(0,0,8'h00,1, 1,1,8'h03,0, 3,1));
        tbl.push_back(v(0,0,8'h00,1, 1,1,8'h04,0, 2,1));
        tbl.push_back(v(0,0,8'h00,1, 1,1,8'h05,1, 1,1));
        tbl.push_back(v(0,0,8'h00,0, 1,0,8'h00,0, 0,0));
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("rst s_ready", 64'(s_if.ready), 64'(0));
        chk("rst m_valid", 64'(m_if.valid), 64'(0));
        chk("rst level", 64'(level), 64'(0));
        chk("rst burst_count", 64'(burst_count), 64'(0));
        resetn = 1'b1;
        chk("s_ready before first edge", 64'(s_if.ready), 64'(0));
        @(posedge clk); #1;
        chk("s_ready after release", 64'(s_if.ready), 64'(1));

        foreach (tbl[i]) begin
            s_if.valid = tbl[i].sv;
            s_if.last  = tbl[i].sl;
            s_if.data  = {8{tbl[i].sd}};
            m_if.ready = tbl[i].mr;
            chk($sformatf("v%0d s_ready", i), 64'(s_if.ready), 64'(tbl[i].sr));
            chk($sformatf("v%0d m_valid", i), 64'(m_if.valid), 64'(tbl[i].mv));
            if (tbl[i].mv) begin
                chk($sformatf("v%0d m_data", i), m_if.data, {8{tbl[i].md}});
                chk($sformatf("v%0d m_last", i), 64'(m_if.last), 64'(tbl[i].ml));
            end
            chk($sformatf("v%0d level", i), 64'(level), 64'(tbl[i].lvl));
            chk($sformatf("v%0d burst_count", i), 64'(burst_count), 64'(tbl[i].bc));
            @(posedge clk); #1;
        end

        // Reset while beats are buffered: everything stored must vanish.
        m_if.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_if.valid = 1'b1;
            s_if.data  = {8{8'hC0 + 8'(i)}};
            s_if.last  = (i == 2);
            @(posedge clk); #1;
        end
        s_if.valid = 1'b0;
        chk("pre-reset level", 64'(level), 64'(3));
        chk("pre-reset burst_count", 64'(burst_count), 64'(1));
        #2 resetn = 1'b0;
        #1;
        chk("mid rst level", 64'(level), 64'(0));
        chk("mid rst burst_count", 64'(burst_count), 64'(0));
        chk("mid rst m_valid", 64'(m_if.valid), 64'(0));
        chk("mid rst s_ready", 64'(s_if.ready), 64'(0));
        m_if.ready = 1'b1;
        #2 resetn = 1'b1;
        @(posedge clk); #1;
        chk("post rst s_ready", 64'(s_if.ready), 64'(1));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("post rst m_valid %0d", i), 64'(m_if.valid), 64'(0));
            chk($sformatf("post rst level %0d", i), 64'(level), 64'(0));
            @(posedge clk); #1;
        end
        m_if.ready = 1'b0;

        src_q.delete();
        for (int i = 0; i < 30; i++) src_q.push_back({i % 3 == 2, 64'h5A00_0000_0000_0000 | 64'(i)});
        stream(1'b0, "steady");

        src_q.delete();
        for (int i = 0; i < 10; i++) src_q.push_back({i == 9, 64'hB000_0000_0000_0000 | 64'(i)});
        stream(1'b0, "long burst");

        src_q.delete();
        for (int b = 0; b < 200; b++) begin
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) src_q.push_back({k == len - 1, $urandom, $urandom});
        end
        stream(1'b1, "random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
